// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receive and transmit paths
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for an asynchronous input pin
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 with one-entry holding register
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BAUD = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  localparam int CNT_W = $clog2(TICKS_PER_BAUD);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(TICKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock  (clock),
    .reset  (reset),
    .async_i(rx),
    .sync_o (rx_s)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 frame_done;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    pe_d       = 1'b0;
`endif

    if (valid_q && ready) valid_d = 1'b0;

    // Counter free-runs only while a frame is being timed.
    if (state_q != WAIT_IDLE && state_q != IDLE)
      cnt_d = tick ? RELOAD : cnt_q - 1'b1;

    case (state_q)
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) pe_d = 1'b1;
            else frame_done = 1'b1;
`else
            frame_done = 1'b1;
`endif
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (frame_done) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx (optionally with UART_RX_PARITY_EN)
module tb_uart_rx;

  localparam int T = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // Start edge on the pin to the stop-bit sample edge.
  localparam int LAT = 155 + T * EXTRA;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
  logic       par_flip = 1'b0;
`endif

  always #5 clock = ~clock;

  uart_rx #(.TICKS_PER_BAUD(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .framing_error(framing_error),
    .overrun      (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error (parity_error)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_error) pe_cnt++;
`endif
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %0h expected none", data);
        end else begin
          check("byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (T) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cycles);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    rx = stop_v;
    repeat (stop_cycles) @(posedge clock);
    #1;
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_data", {24'd0, data}, 0);
    check("reset_fe", {31'd0, framing_error}, 0);
    check("reset_ov", {31'd0, overrun}, 0);
    reset = 1'b0;
    idle(10);

    // Basic frame and pin-to-valid latency
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, T);
      begin
        k = 0;
        while (!valid && k < 300) begin
          @(posedge clock);
          #1;
          k++;
        end
        check("latency_in_range", {31'd0, (k >= LAT - 1 && k <= LAT + 1)}, 1);
      end
    join
    idle(20);
    check("a5_no_fe", fe_cnt, 0);
    check("a5_no_ov", ov_cnt, 0);

    // Short glitch, then a real frame
    rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idle(40);
    check("glitch_no_valid", {31'd0, valid}, 0);
    check("glitch_no_fe", fe_cnt, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, T);
    idle(20);

    // Break: stop bit held low
    send_frame(8'h00, 1'b0, 40);
    idle(20);
    check("break_one_fe", fe_cnt, 1);
    check("break_no_valid", {31'd0, valid}, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, T);
    idle(20);

    // Overrun
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, T);
    idle(5);
    send_frame(8'h22, 1'b1, T);
    idle(5);
    check("overrun_pulse", ov_cnt, 1);
    check("overrun_valid_kept", {31'd0, valid}, 1);
    check("overrun_data_kept", {24'd0, data}, 32'h11);
    ready = 1'b1;
    @(posedge clock);
    #1;
    ready = 1'b0;
    check("consume_clears_valid", {31'd0, valid}, 0);

    // Consume in the exact completion cycle: no overrun
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, T);
    idle(5);
    check("pending_valid", {31'd0, valid}, 1);
    fork
      send_frame(8'h22, 1'b1, T);
      begin
        repeat (LAT - 1) @(posedge clock);
        #1;
        ready = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
      end
    join
    check("same_cycle_no_ov", ov_cnt, 1);
    check("same_cycle_valid", {31'd0, valid}, 1);
    check("same_cycle_data", {24'd0, data}, 32'h22);
    ready = 1'b1;
    idle(3);
    check("same_cycle_drained", {31'd0, valid}, 0);

    // Reset mid-frame with the line low
    rx = 1'b0;
    repeat (60) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(40);
    check("midreset_no_valid", {31'd0, valid}, 0);
    check("midreset_no_fe", fe_cnt, 1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, T);
    idle(20);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h5A, 1'b1, T);
    par_flip = 1'b0;
    idle(20);
    check("parity_error_pulse", pe_cnt, 1);
    check("parity_no_valid", {31'd0, valid}, 0);
`endif
    check("pe_total", pe_cnt, EXTRA);
    check("fe_total", fe_cnt, 1);
    check("ov_total", ov_cnt, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
